// File: rtl/grid_shift_out.sv
// Serial row transmitter for the 8x8 Life grid: drives a daisy-chained pair of 74HC595s.
// Define GRID_SHIFT_BLANK_EN to keep the display blanked while a row shifts in.
module grid_shift_out #(
    parameter int CLK_DIV  = 4,
    parameter int ROW_HOLD = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [63:0] i_grid,
    output logic        o_sclk,
    output logic        o_sdata,
    output logic        o_rclk,
    output logic        o_oe_n,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SNAP  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    localparam int MAX_CNT = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ROW_HOLD - 1);

    logic [2:0]       r_state;
    logic [63:0]      r_snap;
    logic [2:0]       r_row;
    logic [3:0]       r_bit;
    logic             r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             r_sdata;
    logic             r_rclk;
    logic             r_oe_n;
    logic             r_busy;
    logic             r_frame_done;

    logic [2:0]       w_state_nxt;
    logic [63:0]      w_snap_nxt;
    logic [2:0]       w_row_nxt;
    logic [3:0]       w_bit_nxt;
    logic             w_phase_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_frame_done_nxt;
    logic [7:0]       w_row_sel;
    logic [15:0]      w_word;
    logic             w_sdata_nxt;
    logic             w_oe_n_nxt;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        w_state_nxt      = r_state;
        w_snap_nxt       = r_snap;
        w_row_nxt        = r_row;
        w_bit_nxt        = r_bit;
        w_phase_nxt      = r_phase;
        w_cnt_nxt        = r_cnt;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state_nxt = ST_SNAP;
            end
            ST_SNAP: begin
                w_snap_nxt  = i_grid;
                w_row_nxt   = 3'd0;
                w_bit_nxt   = 4'd15;
                w_phase_nxt = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else if (r_bit == 4'd0) begin
                        w_state_nxt = ST_LATCH;
                    end else begin
                        w_bit_nxt   = r_bit - 1'b1;
                        w_phase_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_LATCH: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_row != 3'd7) begin
                        w_row_nxt   = r_row + 1'b1;
                        w_bit_nxt   = 4'd15;
                        w_phase_nxt = 1'b0;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_frame_done_nxt = 1'b1;
                        w_state_nxt      = i_enable ? ST_SNAP : ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    assign w_row_sel   = 8'd1 << w_row_nxt;
    assign w_word      = {~w_row_sel, w_snap_nxt[{w_row_nxt, 3'b000} +: 8]};
    assign w_sdata_nxt = (w_state_nxt == ST_SHIFT && !w_phase_nxt) ? w_word[w_bit_nxt] : r_sdata;

`ifdef GRID_SHIFT_BLANK_EN
    assign w_oe_n_nxt = (w_state_nxt != ST_HOLD);
`else
    assign w_oe_n_nxt = !((w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_HOLD));
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_snap       <= '0;
            r_row        <= 3'd0;
            r_bit        <= 4'd15;
            r_phase      <= 1'b0;
            r_cnt        <= '0;
            r_sclk       <= 1'b0;
            r_sdata      <= 1'b0;
            r_rclk       <= 1'b0;
            r_oe_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            r_state      <= w_state_nxt;
            r_snap       <= w_snap_nxt;
            r_row        <= w_row_nxt;
            r_bit        <= w_bit_nxt;
            r_phase      <= w_phase_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sclk       <= (w_state_nxt == ST_SHIFT) && w_phase_nxt;
            r_sdata      <= w_sdata_nxt;
            r_rclk       <= (w_state_nxt == ST_LATCH);
            r_oe_n       <= w_oe_n_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign o_sclk       = r_sclk;
    assign o_sdata      = r_sdata;
    assign o_rclk       = r_rclk;
    assign o_oe_n       = r_oe_n;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule
